// File: rtl/csr_uart_rx.sv
// csr_uart_rx: 8N1 UART receiver with CSR-style valid/ack handshake and sticky error flags
module csr_uart_rx #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       uart_rxd,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic       frame_err,
  output logic       busy
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int TW = $clog2(DIV);
  localparam logic [TW-1:0] FULL = TW'(DIV - 1);
  localparam logic [TW-1:0] HALF = TW'(DIV / 2 - 1);
  if (DIV < 4) begin : g_div_chk
    $error("csr_uart_rx: CLK_HZ/BAUD must be at least 4");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic sync1, rxs, tz, done, ferr_set;
  logic [TW-1:0] timer, timer_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  assign tz = timer == '0;
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (srst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      state <= IDLE;
      timer <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      sync1 <= uart_rxd;
      rxs   <= sync1;
      state <= state_n;
      timer <= timer_n;
      idx   <= idx_n;
      sh    <= sh_n;
    end
  always_comb begin
    state_n  = state;
    timer_n  = tz ? timer : timer - TW'(1);
    idx_n    = idx;
    sh_n     = sh;
    done     = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: if (!rxs) begin
        state_n = START;
        timer_n = HALF;
      end
      START: if (tz) begin
        state_n = rxs ? IDLE : DATA;
        timer_n = FULL;
        idx_n   = '0;
      end
      DATA: if (tz) begin
        sh_n[idx] = rxs;
        timer_n   = FULL;
        idx_n     = idx + 3'd1;
        state_n   = idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (tz) begin
        done     = rxs;
        ferr_set = !rxs;
        state_n  = rxs ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: state_n = rxs ? IDLE : WAIT_IDLE;
      default: state_n = IDLE;
    endcase
  end
  // an ack clears the sticky flags, but a same-cycle new event sets them again
  always_ff @(posedge clk)
    if (srst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (done && (!rx_valid || rx_ack)) rx_data <= sh;
      rx_valid   <= done || (rx_valid && !rx_ack);
      rx_overrun <= (done && rx_valid && !rx_ack) || (rx_overrun && !rx_ack);
      frame_err  <= ferr_set || (frame_err && !rx_ack);
    end
endmodule

// File: tb/tb_csr_uart_rx.sv
// tb_csr_uart_rx: randomized 8N1 frames checked against a frame-level model of the receiver
module tb_csr_uart_rx;
  logic clk, srst, uart_rxd, rx_ack;
  logic [7:0] rx_data;
  logic rx_valid, rx_overrun, frame_err, busy;
  int n_vec = 0, n_err = 0;
  logic [7:0] m_data;
  bit m_v, m_ov, m_fe;

  csr_uart_rx #(.CLK_HZ(1600000), .BAUD(100000)) dut (
    .clk(clk), .srst(srst), .uart_rxd(uart_rxd), .rx_ack(rx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_overrun(rx_overrun),
    .frame_err(frame_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_data"}, rx_data, m_data);
    chk({tag, "_valid"}, 8'(rx_valid), 8'(m_v));
    chk({tag, "_overrun"}, 8'(rx_overrun), 8'(m_ov));
    chk({tag, "_frame_err"}, 8'(frame_err), 8'(m_fe));
    chk({tag, "_busy"}, 8'(busy), 8'd0);
  endtask

  task automatic model_reset();
    m_data = 8'h00;
    m_v = 0;
    m_ov = 0;
    m_fe = 0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit ack);
    if (ack) begin
      m_ov = 0;
      m_fe = 0;
    end
    if (!stop_ok) begin
      if (ack) m_v = 0;
      m_fe = 1;
    end else if (!m_v || ack) begin
      m_data = b;
      m_v = 1;
    end else m_ov = 1;
  endtask

  // one frame: 16 clocks per bit; stop_low>0 holds the stop bit low that many bit times
  task automatic send(input logic [7:0] b, input int stop_low, input bit ack_done, input int rst_at);
    int len;
    bit pre_v;
    len = 16 * (10 + stop_low);
    pre_v = m_v;
    if (rst_at < 0) model_frame(b, stop_low == 0, ack_done);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      uart_rxd = (c / 16 == 0) ? 1'b0 : (c / 16 <= 8) ? b[c/16-1] : (c / 16 < 9 + stop_low) ? 1'b0 : 1'b1;
      rx_ack = ack_done && c == 154;
      srst = rst_at >= 0 && c >= rst_at && c < rst_at + 2;
      if (rst_at < 0) begin
        if (c == 100) chk("busy_mid", 8'(busy), 8'd1);
        if (c == 154) chk("valid_pre", 8'(rx_valid), 8'(pre_v));
        if (c == 155) chk("valid_post", 8'(rx_valid), 8'(m_v));
        if (stop_low > 0 && c == 170) chk("busy_wait_idle", 8'(busy), 8'd1);
      end else if (c == rst_at + 2) begin
        model_reset();
        check_all("in_reset");
      end
    end
    rx_ack = 1'b0;
    srst = 1'b0;
    uart_rxd = 1'b1;
    repeat (24) @(negedge clk);
    check_all("frame");
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    m_v = 0;
    m_ov = 0;
    m_fe = 0;
    @(negedge clk);
    check_all("ack");
  endtask

  task automatic glitch(input int n);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (n - 1) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (20) @(negedge clk);
    check_all("glitch");
  endtask

  initial begin
    srst = 1'b1;
    uart_rxd = 1'b1;
    rx_ack = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check_all("reset");
    srst = 1'b0;
    repeat (4) @(negedge clk);
    send(8'hA5, 0, 0, -1);
    pulse_ack();
    send(8'h3C, 0, 0, -1);
    send(8'h81, 0, 0, -1);
    pulse_ack();
    send(8'h55, 2, 0, -1);
    send(8'h0F, 0, 0, -1);
    pulse_ack();
    glitch(5);
    send(8'h11, 0, 0, -1);
    send(8'hF0, 0, 1, -1);
    pulse_ack();
    send(8'hFF, 0, 0, 88);
    send(8'h12, 0, 0, -1);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1) == 1) pulse_ack();
      if ($urandom_range(7) == 0) glitch(int'($urandom_range(6, 1)));
      send(8'($urandom), ($urandom_range(7) == 0) ? 2 : 0, $urandom_range(5) == 0, -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
